// File: rtl/spi_shift_if.sv
// ---------------------------------------------------------------------------
// spi_shift_if : bundle of control, strobe and data signals between the SPI
// shift register (slave side) and whatever drives it (master side).
//
//   go, latch       start strobe / load p_in into the TX register
//   p_in, p_out     parallel TX word / parallel RX word (2**LEN_W bits)
//   len, lsb        character length (0 = full width), bit order
//   tx_negedge,
//   rx_negedge      select which clkgen strobe drives TX / RX
//   pos_edge,
//   neg_edge        one-cycle strobes from spi_clkgen
//   s_in, s_out     serial MISO / MOSI
//   tip, last_clk   transfer in progress / all TX bits issued
//   done            end-of-transfer pulse, present only when the
//                   SPI_SHIFT_DONE_EN macro is defined
// ---------------------------------------------------------------------------
interface spi_shift_if #(
    parameter int LEN_W = 5
) ();
    localparam int MAX_CHAR = 2 ** LEN_W;

    logic                go;
    logic                latch;
    logic [MAX_CHAR-1:0] p_in;
    logic [LEN_W-1:0]    len;
    logic                lsb;
    logic                tx_negedge;
    logic                rx_negedge;
    logic                pos_edge;
    logic                neg_edge;
    logic                s_in;
    logic                tip;
    logic                last_clk;
    logic                s_out;
    logic [MAX_CHAR-1:0] p_out;
`ifdef SPI_SHIFT_DONE_EN
    logic                done;
`endif

    modport master (
        output go, latch, p_in, len, lsb, tx_negedge, rx_negedge,
        output pos_edge, neg_edge, s_in,
        input  tip, last_clk, s_out, p_out
`ifdef SPI_SHIFT_DONE_EN
        , input done
`endif
    );

    modport slave (
        input  go, latch, p_in, len, lsb, tx_negedge, rx_negedge,
        input  pos_edge, neg_edge, s_in,
        output tip, last_clk, s_out, p_out
`ifdef SPI_SHIFT_DONE_EN
        , output done
`endif
    );
endinterface

// File: rtl/spi_shift.sv
// ---------------------------------------------------------------------------
// spi_shift : serial data path of the SPI master.
//
// Holds a parallel TX word, shifts it out on s_out on the selected clkgen
// strobe, samples s_in into p_out on the other selected strobe, and reports
// tip / last_clk back to spi_clkgen. A transfer ends when the last RX bit has
// been sampled.
//
// Ports:
//   wb_clk  system clock, rising edge
//   wb_rst  asynchronous active-low reset
//   bus     spi_shift_if.slave (see rtl/spi_shift_if.sv)
//
// Optional feature: define SPI_SHIFT_DONE_EN to add bus.done, a one-cycle
// pulse in the first cycle that tip reads low after a completed transfer.
// ---------------------------------------------------------------------------
module spi_shift #(
    parameter int LEN_W = 5
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    spi_shift_if.slave    bus
);
    localparam int MAX_CHAR = 2 ** LEN_W;
    localparam int CNT_W    = LEN_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e              state_q,    state_d;
    logic [MAX_CHAR-1:0] tx_data_q,  tx_data_d;
    logic [MAX_CHAR-1:0] p_out_q,    p_out_d;
    logic [CNT_W-1:0]    tx_cnt_q,   tx_cnt_d;
    logic [CNT_W-1:0]    rx_cnt_q,   rx_cnt_d;
    logic [CNT_W-1:0]    n_q,        n_d;
    logic                tip_q,      tip_d;
    logic                last_clk_q, last_clk_d;
    logic                s_out_q,    s_out_d;

    logic [CNT_W-1:0]    n_s;
    logic                tx_edge_s;
    logic                rx_edge_s;
    logic [LEN_W-1:0]    tx_idx_s;
    logic [LEN_W-1:0]    rx_idx_s;

    // Next-state logic for the IDLE/XFER machine and both shift paths.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        p_out_d    = p_out_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        n_d        = n_q;
        s_out_d    = s_out_q;

        // len==0 encodes the full register width
        n_s       = (bus.len == LEN_W'(0)) ? CNT_W'(MAX_CHAR) : CNT_W'(bus.len);
        tx_edge_s = bus.tx_negedge ? bus.neg_edge : bus.pos_edge;
        rx_edge_s = bus.rx_negedge ? bus.neg_edge : bus.pos_edge;

        // Counters run N..1, so MSB-first index is cnt-1 and LSB-first is N-cnt.
        // Both results lie in 0..MAX_CHAR-1, so the top counter bit can go.
        tx_idx_s  = LEN_W'(bus.lsb ? (n_q - tx_cnt_q) : (tx_cnt_q - CNT_W'(1)));
        rx_idx_s  = LEN_W'(bus.lsb ? (n_q - rx_cnt_q) : (rx_cnt_q - CNT_W'(1)));

        case (state_q)
            ST_IDLE: begin
                // latch and go together: the transfer uses the new word
                if (bus.latch) begin
                    tx_data_d = bus.p_in;
                end else begin
                    tx_data_d = tx_data_q;
                end
                if (bus.go) begin
                    state_d  = ST_XFER;
                    n_d      = n_s;
                    tx_cnt_d = n_s;
                    rx_cnt_d = n_s;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (tx_edge_s && (tx_cnt_q != CNT_W'(0))) begin
                    s_out_d  = tx_data_q[tx_idx_s];
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end else begin
                    s_out_d  = s_out_q;
                end
                if (rx_edge_s && (rx_cnt_q != CNT_W'(0))) begin
                    p_out_d[rx_idx_s] = bus.s_in;
                    rx_cnt_d          = rx_cnt_q - CNT_W'(1);
                    // the final RX sample ends the transfer
                    if (rx_cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are computed from next-state values so the flops show
        // them in the same cycle as the state/counter they describe.
        tip_d      = (state_d == ST_XFER);
        last_clk_d = tip_d && (tx_cnt_d == CNT_W'(0));
    end

    // State, data and registered status outputs.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            p_out_q    <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            n_q        <= '0;
            tip_q      <= 1'b0;
            last_clk_q <= 1'b0;
            s_out_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            p_out_q    <= p_out_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            n_q        <= n_d;
            tip_q      <= tip_d;
            last_clk_q <= last_clk_d;
            s_out_q    <= s_out_d;
        end
    end

    assign bus.tip      = tip_q;
    assign bus.last_clk = last_clk_q;
    assign bus.s_out    = s_out_q;
    assign bus.p_out    = p_out_q;

`ifdef SPI_SHIFT_DONE_EN
    logic done_q;

    // One-cycle pulse alongside the tip 1->0 transition; reset clears it.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= tip_q && !tip_d;
        end
    end

    assign bus.done = done_q;
`endif

endmodule

// File: doc/spi_shift.md
Name: spi_shift

Overview:
- Serial data path for the SPI master; sits directly beside spi_clkgen and consumes its edge strobes.
- Uses cpol_1 (pos_edge) and cpol_0 (neg_edge) from spi_clkgen.
- Produces tip and last_clk, which spi_clkgen uses to start and stop sclk_out.
- Holds a parallel TX word, shifts it out on s_out, samples s_in into a parallel RX word, and signals end of transfer.

Parameters:
- LEN_W, 5: width of len. MAX_CHAR = 2**LEN_W = 32 bits, which is also the width of the data registers.

Ports:
- wb_clk  in  1  system clock; all logic on the rising edge.
- wb_rst  in  1  asynchronous, active-low reset.
- go  in  1  start-transfer strobe, sampled only in IDLE.
- latch  in  1  loads p_in into tx_data, sampled only in IDLE.
- p_in  in  32  parallel TX word.
- len  in  LEN_W  character length; 0 means 32 bits.
- lsb  in  1  1 = LSB first, 0 = MSB first.
- tx_negedge  in  1  1 = drive s_out on neg_edge, 0 = on pos_edge.
- rx_negedge  in  1  1 = sample s_in on neg_edge, 0 = on pos_edge.
- pos_edge  in  1  1-cycle strobe from spi_clkgen cpol_1.
- neg_edge  in  1  1-cycle strobe from spi_clkgen cpol_0.
- s_in  in  1  serial input (MISO).
- tip  out  1  transfer in progress.
- last_clk  out  1  all TX bits issued; drives spi_clkgen last_clk.
- s_out  out  1  serial output (MOSI).
- p_out  out  32  parallel RX word.

Behaviour:
- Reset (wb_rst=0, async): state=IDLE; tip=0, last_clk=0, s_out=0, p_out=0, tx_data=0, counters=0.
- Derived signals:
  - N = (len==0) ? 32 : len.
  - tx_edge = tx_negedge ? neg_edge : pos_edge.
  - rx_edge = rx_negedge ? neg_edge : pos_edge.
- FSM states IDLE and XFER; tip = (state==XFER), registered.
- IDLE:
  - latch=1 → tx_data <= p_in.
  - go=1 → state <= XFER, tx_cnt <= N, rx_cnt <= N, and N is latched internally.
  - latch and go in the same cycle: both honoured; the transfer sends the newly latched word.
  - Edge strobes in IDLE, including the go cycle, are ignored.
  - s_out holds its last value.
- XFER, TX side:
  - On tx_edge with tx_cnt != 0: s_out <= tx_data[idx], tx_cnt <= tx_cnt-1.
  - idx = lsb ? (N - tx_cnt) : (tx_cnt - 1).
- XFER, RX side:
  - On rx_edge with rx_cnt != 0: p_out[idx_r] <= s_in, rx_cnt <= rx_cnt-1.
  - idx_r uses the same formula with rx_cnt.
  - Bits of p_out at positions >= N are left unchanged.
- last_clk = tip & (tx_cnt==0), registered; asserted from the cycle after the final tx_edge until tip falls.
- Completion: when rx_edge decrements rx_cnt from 1 to 0, state <= IDLE, so tip falls on the following cycle. p_out is stable from that cycle.
- tx_edge and rx_edge in the same cycle: both are processed independently.
- pos_edge and neg_edge both high in one cycle: legal; each path uses only its selected strobe.
- go or latch during XFER: ignored. Changes to p_in, len, lsb, tx_negedge or rx_negedge during XFER do not affect the transfer in flight; N is latched at go, the others are sampled per edge and must be held stable by software.
- Reset mid-transfer: immediate abort to reset values; no partial p_out is retained.
- Latency:
  - go → tip=1 after 1 cycle.
  - Final rx_edge → tip=0 after 1 cycle.

Optional Feature:
- Macro SPI_SHIFT_DONE_EN.
- Defined: adds output `done` (1 bit, reset 0), a 1-cycle pulse in the same cycle tip goes from 1 to 0. Not asserted on a reset abort.
- Undefined: no `done` port; all other behaviour identical.

Test Plan:
- Reset checks:
  - Assert wb_rst=0 mid-XFER at bit 3 of an 8-bit transfer → tip, last_clk, s_out and p_out all 0 asynchronously.
  - After release → IDLE; a new go is accepted.
- MSB-first TX:
  - Setup: latch p_in=32'h000000A5, len=8, lsb=0, tx_negedge=1, rx_negedge=0, alternate neg/pos strobes every 4 cycles.
  - s_out sequence → 1,0,1,0,0,1,0,1.
  - last_clk → rises after the 8th neg_edge.
  - tip → falls 1 cycle after the 8th pos_edge.
- LSB-first RX:
  - Setup: len=8, lsb=1, s_in driven 1,1,0,0,1,0,1,0 on successive rx_edges.
  - p_out[7:0] → 8'h53.
- Full length:
  - len=0, tx_data=32'h80000001, lsb=0.
  - Exactly 32 tx_edges occur before last_clk.
  - s_out → first bit 1, bits 2-31 all 0, last bit 1.
- Ignored strobes:
  - go and latch with p_in=32'hFFFFFFFF asserted during XFER → tx_data and the counters are unchanged; the transfer completes with the original data.
  - Edge strobes in IDLE → s_out and p_out unchanged.
- SPI_SHIFT_DONE_EN:
  - Defined: done pulses for exactly 1 cycle, coincident with tip 1→0.
  - Undefined: the bench compiles without the `done` port.
